axis_pack: RTL
==============

AXIS_PACK -- requirements
Module: axis_pack

Interface
REQ-001 The block SHALL have parameter WIDTH_P, default 64: wide output data width in bits.
REQ-002 The block SHALL have parameter WIDTH_S, default 32: narrow input data width in bits; WIDTH_P SHALL equal 2*WIDTH_S.
REQ-003 The block SHALL have port clk_s, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_s, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port cfg, input, 2 bits: packing mode (00 LSB, 01 MSB, 10 LITTLE_ENDIAN, 11 BIG_ENDIAN).
REQ-006 The block SHALL have port s_axis_data, input, WIDTH_S bits: narrow input beat.
REQ-007 The block SHALL have ports s_axis_valid (input, 1), s_axis_last (input, 1) and s_axis_ready (output, 1): the input handshake.
REQ-008 The block SHALL have port p_axis_data, output, WIDTH_P bits: wide output word.
REQ-009 The block SHALL have ports p_axis_valid (output, 1), p_axis_last (output, 1) and p_axis_ready (input, 1): the output handshake.

Function
REQ-010 An input transfer SHALL occur when s_axis_valid && s_axis_ready; an output transfer SHALL occur when p_axis_valid && p_axis_ready.
REQ-011 The assembly FSM SHALL have exactly two states: EMPTY (no half held) and HALF (first narrow beat held).
REQ-012 cfg SHALL be sampled only on an input transfer in EMPTY; in HALF the mode latched at the first beat SHALL apply, and cfg changes mid-pair SHALL be ignored.
REQ-013 LSB mode: each beat SHALL produce one wide word {WIDTH_S'0, beat}, with last copied; the FSM stays in EMPTY.
REQ-014 MSB mode: each beat SHALL produce one wide word {beat, WIDTH_S'0}, with last copied; the FSM stays in EMPTY.
REQ-015 LITTLE_ENDIAN mode: the first beat SHALL be held (EMPTY->HALF); the second beat SHALL produce {second, first} (HALF->EMPTY), with last = second beat's last.
REQ-016 BIG_ENDIAN mode: as REQ-015, but the output word SHALL be {first, second}.
REQ-017 Flush: in LITTLE_ENDIAN or BIG_ENDIAN, a first beat with s_axis_last=1 SHALL produce one word immediately, with the beat in the low half (LITTLE_ENDIAN) or high half (BIG_ENDIAN), the other half zero, and last=1; the FSM stays in EMPTY.
REQ-018 The output SHALL be one registered stage: p_axis_data, p_axis_valid and p_axis_last SHALL be updated on the clock edge after the completing input beat (latency 1 cycle).
REQ-019 s_axis_ready SHALL equal !p_axis_valid || p_axis_ready (combinational, no dependency on s_axis_valid).
REQ-020 A beat that does not complete a word (first half in HALF transition) SHALL be accepted under the same ready rule.
REQ-021 p_axis_data and p_axis_last SHALL hold stable while p_axis_valid && !p_axis_ready.
REQ-022 Simultaneous output transfer and completing input beat SHALL load the new word with p_axis_valid remaining 1, giving full throughput of one wide word per cycle in LSB/MSB mode.
REQ-023 p_axis_valid SHALL clear on an output transfer with no new completing beat.

Reset
REQ-024 While rst_s=1, the FSM SHALL go to EMPTY, p_axis_valid, p_axis_last and p_axis_data SHALL be 0, and the held half SHALL be 0.
REQ-025 Reset asserted mid-pair or with a pending output SHALL discard that data; no partial word SHALL be emitted after reset.
REQ-026 s_axis_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-027 With macro AXIS_PACK_KEEP_EN defined, the block SHALL add output p_axis_keep, WIDTH_P/8 bits, registered with the data: all ones for full pairs, low-half ones for LSB or LITTLE_ENDIAN flush, high-half ones for MSB or BIG_ENDIAN flush, and 0 at reset.
REQ-028 Without AXIS_PACK_KEEP_EN, the p_axis_keep port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 cfg=00, beats 0x11111111, 0x22222222 (last) with p_axis_ready=1 SHALL produce 0x0000000011111111 (last 0), then 0x0000000022222222 (last 1), each one cycle after input.
REQ-030 cfg=10, beats 0xAAAAAAAA, 0xBBBBBBBB (last) SHALL produce a single word 0xBBBBBBBBAAAAAAAA with last=1; cfg=11 with the same beats SHALL produce 0xAAAAAAAABBBBBBBB.
REQ-031 cfg=11, single beat 0xCCCCCCCC with last=1 SHALL produce 0xCCCCCCCC00000000 with last=1 (and keep=0xF0 when AXIS_PACK_KEEP_EN is defined).
REQ-032 cfg=10, first beat accepted, cfg switched to 00, second beat 0xDD SHALL still produce a packed pair 0x000000DD_<first>.
REQ-033 p_axis_ready=0 for 5 cycles while the output is valid SHALL hold s_axis_ready=0 and the output stable; on release, transfer SHALL resume without loss or duplication.
REQ-034 rst_s pulsed while in HALF SHALL clear p_axis_valid and discard the held beat; the next two beats SHALL form a fresh pair.

Source files
------------

// File: rtl/axis_pack_if.sv
// rtl/axis_pack_if.sv - valid/ready/last stream bundle used on both sides of axis_pack
//
// Purpose: groups one stream's data, valid, last and ready signals.
// Parameter W is the data width.
// Modports:
//   master - drives data/valid/last and receives ready
//   slave  - receives data/valid/last and drives ready
interface axis_pack_if #(
  parameter int W = 32
);
  logic [W-1:0] data;
  logic         valid;
  logic         last;
  logic         ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/axis_pack.sv
// rtl/axis_pack.sv - packs narrow stream beats into wide words (LSB/MSB/LE/BE modes)
//
// Purpose: converts a WIDTH_S-bit input stream into a WIDTH_P-bit output stream
// (WIDTH_P = 2*WIDTH_S). The output goes through a single register stage.
// Ports:
//   clk_s          - clock, rising edge
//   rst_s          - synchronous active-high reset
//   cfg[1:0]       - mode: 00 LSB, 01 MSB, 10 LITTLE_ENDIAN, 11 BIG_ENDIAN
//   s_axis (slave) - narrow input stream (data/valid/last in, ready out)
//   p_axis (master)- wide output stream (data/valid/last out, ready in)
//   p_axis_keep    - byte enables for p_axis data, present only with AXIS_PACK_KEEP_EN
// Optional feature macro: AXIS_PACK_KEEP_EN
module axis_pack #(
  parameter int WIDTH_P = 64,
  parameter int WIDTH_S = 32
) (
  input  logic        clk_s,
  input  logic        rst_s,
  input  logic [1:0]  cfg,
  axis_pack_if.slave  s_axis,
  axis_pack_if.master p_axis
`ifdef AXIS_PACK_KEEP_EN
  ,
  output logic [WIDTH_P/8-1:0] p_axis_keep
`endif
);

  localparam int KW = WIDTH_P / 8;
  localparam int HW = KW / 2;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  state_t               state_q;
  logic [WIDTH_S-1:0]   half_q;
  logic                 big_q;    // mode of the held pair: 1 = BIG_ENDIAN
  logic [WIDTH_P-1:0]   data_q;
  logic                 valid_q;
  logic                 last_q;
  logic                 s_ready;
  logic                 in_xfer;
`ifdef AXIS_PACK_KEEP_EN
  logic [KW-1:0]        keep_q;
`endif

  // Room exists whenever the output register is empty or draining this cycle.
  assign s_ready        = !valid_q || p_axis.ready;
  assign in_xfer        = s_axis.valid && s_ready;

  assign s_axis.ready   = s_ready;
  assign p_axis.data    = data_q;
  assign p_axis.valid   = valid_q;
  assign p_axis.last    = last_q;
`ifdef AXIS_PACK_KEEP_EN
  assign p_axis_keep    = keep_q;
`endif

  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state_q <= EMPTY;
      half_q  <= '0;
      big_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef AXIS_PACK_KEEP_EN
      keep_q  <= '0;
`endif
    end else begin
      // Drain first; a completing beat below overrides this and keeps valid high.
      if (valid_q && p_axis.ready) begin
        valid_q <= 1'b0;
      end

      if (in_xfer) begin
        case (state_q)
          EMPTY: begin
            if (cfg[1] && !s_axis.last) begin
              // First half of an endian pair: hold it and freeze the mode.
              half_q  <= s_axis.data;
              big_q   <= cfg[0];
              state_q <= HALF;
            end else begin
              // Single-beat word: LSB mode and LE flush land low,
              // MSB mode and BE flush land high, so cfg[0] picks the half.
              valid_q <= 1'b1;
              last_q  <= s_axis.last;
              if (cfg[0]) begin
                data_q <= {s_axis.data, {WIDTH_S{1'b0}}};
`ifdef AXIS_PACK_KEEP_EN
                keep_q <= {{HW{1'b1}}, {HW{1'b0}}};
`endif
              end else begin
                data_q <= {{WIDTH_S{1'b0}}, s_axis.data};
`ifdef AXIS_PACK_KEEP_EN
                keep_q <= {{HW{1'b0}}, {HW{1'b1}}};
`endif
              end
            end
          end
          HALF: begin
            valid_q <= 1'b1;
            last_q  <= s_axis.last;
            if (big_q) begin
              data_q <= {half_q, s_axis.data};
            end else begin
              data_q <= {s_axis.data, half_q};
            end
`ifdef AXIS_PACK_KEEP_EN
            keep_q  <= {KW{1'b1}};
`endif
            half_q  <= '0;
            state_q <= EMPTY;
          end
        endcase
      end
    end
  end

endmodule
